// File: rtl/lsu_dmem.sv
// LSU data memory: byte-lane store merge, 1-cycle load return, post-reset zero sweep.
// Load data is registered, so it appears 1 cycle after the request. stall freezes rd_data and err and blocks stores; busy stalls the pipe during the sweep.
module lsu_dmem #(
    parameter int DEPTH_WORDS    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_size,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          clr_we;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_oor, rd_oor, wr_bad;
    logic [3:0]    wr_be;
    logic [31:0]   wr_rep, wr_old, wr_merged;
    logic          accept, st_ok;
    logic [31:0]   rd_word, rd_shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && clr_cnt == AW'(DEPTH_WORDS - 1)) state_nxt = S_READY;
    end

    always_comb begin
        busy   = (state == S_CLEAR);
        clr_we = (state == S_CLEAR);
    end

    assign wr_idx = wr_addr[AW+1:2];
    assign rd_idx = rd_addr[AW+1:2];
    assign wr_oor = (wr_addr >> (AW + 2)) != 32'd0;
    assign rd_oor = (rd_addr >> (AW + 2)) != 32'd0;

    // Replicate store data across lanes so the byte enables alone select the target bytes.
    always_comb begin
        wr_be  = 4'b0000;
        wr_rep = 32'd0;
        wr_bad = 1'b0;
        case (wr_size)
            2'b00: begin
                wr_be  = 4'b0001 << wr_addr[1:0];
                wr_rep = {4{wr_data[7:0]}};
            end
            2'b01: begin
                wr_be  = wr_addr[1] ? 4'b1100 : 4'b0011;
                wr_rep = {2{wr_data[15:0]}};
                wr_bad = wr_addr[0];
            end
            2'b10: begin
                wr_be  = 4'b1111;
                wr_rep = wr_data;
                wr_bad = |wr_addr[1:0];
            end
            default: wr_bad = 1'b1;
        endcase
        if (wr_oor) wr_bad = 1'b1;
    end

    assign wr_old = mem[wr_idx];

    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) wr_merged[8*i +: 8] = wr_rep[8*i +: 8];
        end
    end

    assign accept = !busy && !stall;
    assign st_ok  = accept && wr_en && !wr_bad;

    // Write-first: a load hitting the word being stored sees the merged value.
    assign rd_word    = (st_ok && wr_idx == rd_idx) ? wr_merged : mem[rd_idx];
    assign rd_shifted = rd_word >> {rd_addr[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (clr_we)     mem[clr_cnt] <= 32'd0;
        else if (st_ok) mem[wr_idx]  <= wr_merged;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= 32'd0;
            err     <= 1'b0;
        end else if (busy) begin
            rd_data <= 32'd0;
            err     <= 1'b0;
        end else if (!stall) begin
            err <= (wr_en && wr_bad) || (rd_en && rd_oor);
            if (rd_en) rd_data <= rd_oor ? 32'd0 : rd_shifted;
        end
    end
endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem with DEPTH_WORDS=16: directed vector table, random traffic vs a byte-array model, reset-during-sweep.
module tb_lsu_dmem;
    localparam int DEPTH = 16;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_size = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        err;

    lsu_dmem #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_size(wr_size), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a flat byte array plus the observable output registers.
    logic [7:0]  mb [BYTES];
    int          clear_cnt = 0;
    logic [31:0] rd_m = '0;
    logic        err_m = 1'b0;

    typedef struct {
        logic        s;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [1:0]  ws;
        logic        re;
        logic [31:0] ra;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request cycle (entered and left at a negedge), advance the model, compare after the edge.
    task automatic step(input logic s, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [1:0] ws, input logic re, input logic [31:0] ra);
        logic        drop;
        int          n;
        int          b;
        logic [31:0] w;
        stall = s; wr_en = we; wr_addr = wa; wr_data = wd; wr_size = ws; rd_en = re; rd_addr = ra;
        if (clear_cnt < DEPTH) begin
            rd_m  = '0;
            err_m = 1'b0;
            clear_cnt++;
            if (clear_cnt == DEPTH) for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
        end else if (!s) begin
            drop = (wa >= BYTES) || (ws == 2'd3) || (ws == 2'd1 && wa[0]) || (ws == 2'd2 && wa[1:0] != 2'd0);
            if (we && !drop) begin
                n = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 2 : 4;
                for (int i = 0; i < n; i++) mb[int'(wa) + i] = wd[8*i +: 8];
            end
            if (re) begin
                if (ra >= BYTES) rd_m = '0;
                else begin
                    b = int'(ra) & ~3;
                    w = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
                    rd_m = w >> (8 * int'(ra[1:0]));
                end
            end
            err_m = (we && drop) || (re && ra >= BYTES);
        end
        @(posedge clk);
        #1;
        chk("rd_data", rd_data, rd_m);
        chk("err", 32'(err), 32'(err_m));
        chk("busy", 32'(busy), (clear_cnt < DEPTH) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0);
    endtask

    // Assert reset asynchronously between edges, check outputs clear at once, release at the next negedge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        clear_cnt = 0;
        rd_m = '0;
        err_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            idle();
            n++;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'h0001_0000 | 32'($urandom_range(0, 63));
        if (r < 3)  return 32'($urandom_range(BYTES, BYTES + 15));
        return 32'($urandom_range(0, BYTES - 1));
    endfunction

    initial begin
        int n;
        tbl[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h13,       32'h000000DE, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h11, 32'h000000AA, 2'd0, 1'b0, 32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h12, 32'h00001234, 2'd1, 1'b0, 32'h0,        32'h000000DE, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h10,       32'h1234AAEF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h06, 32'hFFFFFFFF, 2'd2, 1'b0, 32'h0,        32'h1234AAEF, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b0, 32'h0,        32'h1234AAEF, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h05, 32'h0000FFFF, 2'd1, 1'b0, 32'h0,        32'h1234AAEF, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h08, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h0,        32'h1234AAEF, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h40000000, 32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h04,       32'h00000000, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h08,       32'h00000000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h20, 32'h55667788, 2'd2, 1'b1, 32'h20,       32'h55667788, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h10,       32'h1234AAEF, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 32'h24, 32'h99999999, 2'd2, 1'b1, 32'h24,       32'h1234AAEF, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h24,       32'h00000000, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 32'h28, 32'h0BADF00D, 2'd2, 1'b1, 32'h20,       32'h55667788, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b1, 32'h28,       32'h0BADF00D, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 32'h2A, 32'h12345678, 2'd2, 1'b1, 32'h80,       32'h00000000, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 32'h0,  32'h0,        2'd0, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 32'h0,  32'h0,        2'd0, 1'b0, 32'h0,        32'h00000000, 1'b0};

        @(negedge clk);
        do_reset();

        // Load issued during the sweep is ignored and returns zero.
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h3C);
        chk("busy_load_rd", rd_data, 32'h0);
        count_busy(n);
        chk("busy_cycles", 32'(n + 1), 32'd16);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h3C);
        chk("post_clear_3c", rd_data, 32'h0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].s, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ws, tbl[i].re, tbl[i].ra);
            chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_addr());
        end

        // Reset from READY with non-zero rd_data, then again at sweep count 7.
        step(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 2'd2, 1'b1, 32'h0);
        chk("pre_reset_rd", rd_data, 32'hCAFEF00D);
        do_reset();
        for (int i = 0; i < 7; i++) idle();
        do_reset();
        count_busy(n);
        chk("busy_cycles_restart", 32'(n), 32'd16);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0);
        chk("post_reclear_0", rd_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
